// File: rtl/vga_rect_fill.sv
// vga_rect_fill: fills an axis-aligned rectangle by emitting one pixel strobe
// per point, scanning column-major (y increments fastest), with a
// programmable number of idle cycles between pixels.
//
// Ports:
//   CLOCK_50            system clock
//   reset               synchronous, active-high
//   start               request pulse, accepted only in IDLE
//   mode                0 solid, 1 colour-cycle, 2 clear (colour 0), 3 screen reset
//   x0, x1, y0, y1      rectangle corners (any order; clamped to X_MAX/Y_MAX)
//   colour_in           fill colour for mode 0
//   div                 idle cycles between consecutive pixels
//   x, y, colour, plot  pixel output; x/y/colour hold their values while plot=0
//   vga_resetn          active-low one-cycle screen-clear pulse (mode 3)
//   busy                operation in progress
//   done                one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | waiting for start
// PLOT      | plot=1 this cycle, x/y/colour valid
// WAIT      | pacing gap of div cycles between pixels
// RSTPULSE  | vga_resetn=0 for one cycle
// DONE      | done=1, busy=0 for one cycle
module vga_rect_fill #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119,
    parameter int DIV_W = 10
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [X_W-1:0]   x0,
    input  logic [X_W-1:0]   x1,
    input  logic [Y_W-1:0]   y0,
    input  logic [Y_W-1:0]   y1,
    input  logic [C_W-1:0]   colour_in,
    input  logic [DIV_W-1:0] div,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   colour,
    output logic             plot,
    output logic             vga_resetn,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PLOT, S_WAIT, S_RSTPULSE, S_DONE
    } state_t;

    localparam logic [X_W-1:0] XM    = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YM    = Y_W'(Y_MAX);
    localparam logic [C_W-1:0] C_ONE = C_W'(1);
    localparam logic [C_W-1:0] C_TOP = {C_W{1'b1}};

    state_t           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d, xlo_q, xlo_d, xhi_q, xhi_d;
    logic [Y_W-1:0]   y_q, y_d, ylo_q, ylo_d, yhi_q, yhi_d;
    logic [C_W-1:0]   colour_q, colour_d;
    logic [1:0]       mode_q, mode_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic             plot_q, plot_d, vga_resetn_q, vga_resetn_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [X_W-1:0] xa, xb, x_nx;
    logic [Y_W-1:0] ya, yb, y_nx;
    logic [C_W-1:0] c_nx;
    logic           last_px;

    always_comb begin
        xa = (x0 > XM) ? XM : x0;
        xb = (x1 > XM) ? XM : x1;
        ya = (y0 > YM) ? YM : y0;
        yb = (y1 > YM) ? YM : y1;

        // next pixel in column-major order; x only advances below xhi so it
        // can never pass the clamped bound
        last_px = (x_q == xhi_q) && (y_q == yhi_q);
        if (y_q == yhi_q) begin
            y_nx = ylo_q;
            x_nx = x_q + X_W'(1);
        end else begin
            y_nx = y_q + Y_W'(1);
            x_nx = x_q;
        end
        // colour-cycle skips 0 so cycled pixels are never black
        if (mode_q == 2'd1)
            c_nx = (colour_q == C_TOP) ? C_ONE : colour_q + C_ONE;
        else
            c_nx = colour_q;
    end

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        xlo_d        = xlo_q;
        xhi_d        = xhi_q;
        ylo_d        = ylo_q;
        yhi_d        = yhi_q;
        mode_d       = mode_q;
        div_d        = div_q;
        cnt_d        = cnt_q;
        plot_d       = 1'b0;
        vga_resetn_d = 1'b1;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    xlo_d  = (xa < xb) ? xa : xb;
                    xhi_d  = (xa < xb) ? xb : xa;
                    ylo_d  = (ya < yb) ? ya : yb;
                    yhi_d  = (ya < yb) ? yb : ya;
                    mode_d = mode;
                    div_d  = div;
                    busy_d = 1'b1;
                    if (mode == 2'd3) begin
                        state_d      = S_RSTPULSE;
                        vga_resetn_d = 1'b0;
                    end else begin
                        state_d = S_PLOT;
                        plot_d  = 1'b1;
                        x_d     = (xa < xb) ? xa : xb;
                        y_d     = (ya < yb) ? ya : yb;
                        case (mode)
                            2'd1:    colour_d = C_ONE;
                            2'd2:    colour_d = '0;
                            default: colour_d = colour_in;
                        endcase
                    end
                end
            end
            S_PLOT: begin
                if (last_px) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (div_q == '0) begin
                    plot_d   = 1'b1;
                    x_d      = x_nx;
                    y_d      = y_nx;
                    colour_d = c_nx;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = div_q;
                end
            end
            S_WAIT: begin
                if (cnt_q == DIV_W'(1)) begin
                    state_d  = S_PLOT;
                    plot_d   = 1'b1;
                    x_d      = x_nx;
                    y_d      = y_nx;
                    colour_d = c_nx;
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            S_RSTPULSE: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            xlo_q        <= '0;
            xhi_q        <= '0;
            ylo_q        <= '0;
            yhi_q        <= '0;
            mode_q       <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            plot_q       <= 1'b0;
            vga_resetn_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            xlo_q        <= xlo_d;
            xhi_q        <= xhi_d;
            ylo_q        <= ylo_d;
            yhi_q        <= yhi_d;
            mode_q       <= mode_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            plot_q       <= plot_d;
            vga_resetn_q <= vga_resetn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign vga_resetn = vga_resetn_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed testbench for vga_rect_fill with hand-computed expected pixels.
module tb_vga_rect_fill;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] colour_in = '0;
    logic [9:0] div = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, vga_resetn, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int ex_x [16];
    int ex_y [16];
    int ex_c [16];

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_rect_fill dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .mode(mode),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour_in(colour_in), .div(div),
        .x(x), .y(y), .colour(colour), .plot(plot), .vga_resetn(vga_resetn),
        .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_px(input int i, input int px, input int py, input int pc);
        ex_x[i] = px;
        ex_y[i] = py;
        ex_c[i] = pc;
    endtask

    // Drives one start pulse; on return the first post-acceptance cycle is visible.
    task automatic pulse_start(input logic [1:0] m, input int ax0, input int ax1,
                               input int ay0, input int ay1, input int col, input int d);
        mode      = m;
        x0        = 8'(ax0);
        x1        = 8'(ax1);
        y0        = 7'(ay0);
        y1        = 7'(ay1);
        colour_in = 3'(col);
        div       = 10'(d);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Follows a running operation to its done pulse, comparing every plotted
    // pixel against ex_* and the spacing between plots against gap.
    task automatic follow_op(input string name, input int n_exp, input int gap);
        int  k = 0;
        int  last = 0;
        bit  seen_done = 1'b0;
        for (int cyc = 1; cyc <= 2000 && !seen_done; cyc++) begin
            if (plot) begin
                if (k < n_exp) begin
                    chk({name, "_x"}, 32'(x), 32'(ex_x[k]));
                    chk({name, "_y"}, 32'(y), 32'(ex_y[k]));
                    chk({name, "_colour"}, 32'(colour), 32'(ex_c[k]));
                end
                chk({name, "_gap"}, 32'(cyc - last), (k == 0) ? 32'd1 : 32'(gap));
                chk({name, "_busy"}, 32'(busy), 32'd1);
                last = cyc;
                k++;
            end
            if (done) begin
                chk({name, "_done_busy"}, 32'(busy), 32'd0);
                chk({name, "_done_plot"}, 32'(plot), 32'd0);
                seen_done = 1'b1;
            end else begin
                step();
            end
        end
        chk({name, "_npix"}, 32'(k), 32'(n_exp));
        chk({name, "_done_seen"}, 32'(seen_done), 32'd1);
        step();
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int bad_plot;
        int bad_done;

        // reset state
        step();
        step();
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_colour", 32'(colour), 0);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_vga_resetn", 32'(vga_resetn), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b0;
        step();

        // solid 2x2 with no pacing
        set_px(0, 2, 3, 5);
        set_px(1, 2, 4, 5);
        set_px(2, 3, 3, 5);
        set_px(3, 3, 4, 5);
        pulse_start(2'd0, 2, 3, 3, 4, 5, 0);
        follow_op("solid", 4, 1);
        chk("hold_x", 32'(x), 3);
        chk("hold_y", 32'(y), 4);
        chk("hold_colour", 32'(colour), 5);

        // colour-cycle column, div 2 (corners swapped)
        for (int i = 0; i < 10; i++) set_px(i, 0, i, (i % 7) + 1);
        pulse_start(2'd1, 0, 0, 9, 0, 4, 2);
        follow_op("cycle", 10, 3);

        // clamping of out-of-range corner
        set_px(0, 158, 5, 1);
        set_px(1, 159, 5, 1);
        pulse_start(2'd0, 200, 158, 5, 5, 1, 0);
        follow_op("clamp", 2, 1);

        // screen reset pulse
        pulse_start(2'd3, 0, 0, 0, 0, 0, 0);
        chk("sr_resetn", 32'(vga_resetn), 0);
        chk("sr_busy", 32'(busy), 1);
        chk("sr_plot", 32'(plot), 0);
        step();
        chk("sr_done", 32'(done), 1);
        chk("sr_resetn_after", 32'(vga_resetn), 1);
        chk("sr_plot_done", 32'(plot), 0);
        step();

        // clear mode forces colour 0
        set_px(0, 0, 0, 0);
        pulse_start(2'd2, 0, 0, 0, 0, 6, 0);
        follow_op("clear", 1, 1);

        // restart ignored while busy, then reset with start high mid-WAIT
        pulse_start(2'd0, 0, 0, 0, 3, 7, 3);
        chk("ab_first_plot", 32'(plot), 1);
        step();
        start = 1'b1;
        step();
        chk("ab_ignore_plot", 32'(plot), 0);
        chk("ab_ignore_busy", 32'(busy), 1);
        chk("ab_ignore_y", 32'(y), 0);
        reset = 1'b1;
        step();
        chk("ab_rst_x", 32'(x), 0);
        chk("ab_rst_y", 32'(y), 0);
        chk("ab_rst_colour", 32'(colour), 0);
        chk("ab_rst_plot", 32'(plot), 0);
        chk("ab_rst_resetn", 32'(vga_resetn), 1);
        chk("ab_rst_busy", 32'(busy), 0);
        chk("ab_rst_done", 32'(done), 0);
        reset = 1'b0;
        start = 1'b0;
        bad_plot = 0;
        bad_done = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (plot) bad_plot++;
            if (done) bad_done++;
        end
        chk("ab_no_plot", 32'(bad_plot), 0);
        chk("ab_no_done", 32'(bad_done), 0);

        // start in DONE ignored, start in next IDLE accepted
        pulse_start(2'd0, 5, 5, 5, 5, 2, 0);
        chk("dn_plot", 32'(plot), 1);
        step();
        chk("dn_done", 32'(done), 1);
        x0 = 8'd1; x1 = 8'd1; y0 = 7'd1; y1 = 7'd1; colour_in = 3'd3;
        start = 1'b1;
        step();
        chk("dn_ignored_plot", 32'(plot), 0);
        chk("dn_ignored_busy", 32'(busy), 0);
        step();
        start = 1'b0;
        chk("dn_new_plot", 32'(plot), 1);
        chk("dn_new_x", 32'(x), 1);
        chk("dn_new_colour", 32'(colour), 3);
        step();
        chk("dn_new_done", 32'(done), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_rect_fill.md
VGA_RECT_FILL -- requirements
Module: vga_rect_fill

Interface
REQ-001 SHALL have parameter X_W, default 8, x coordinate width.
REQ-002 SHALL have parameter Y_W, default 7, y coordinate width.
REQ-003 SHALL have parameter C_W, default 3, colour width.
REQ-004 SHALL have parameter X_MAX, default 159, largest legal x.
REQ-005 SHALL have parameter Y_MAX, default 119, largest legal y.
REQ-006 SHALL have parameter DIV_W, default 10, pixel-pacing divider width.
REQ-007 SHALL have ports: CLOCK_50 in 1 system clock; reset in 1 synchronous active-high reset; start in 1 request pulse; mode in 2 (0 solid, 1 colour-cycle, 2 clear, 3 screen-reset); x0,x1 in X_W corners; y0,y1 in Y_W corners; colour_in in C_W; div in DIV_W idle cycles between pixels.
REQ-008 SHALL have outputs: x X_W; y Y_W; colour C_W; plot 1 pixel strobe; vga_resetn 1 active-low screen clear; busy 1; done 1 completion pulse.
REQ-009 SHALL use one clock, CLOCK_50; reset is synchronous and active-high.

Function
REQ-010 SHALL implement states IDLE, PLOT, WAIT, RSTPULSE, DONE.
REQ-011 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-012 On acceptance, SHALL latch mode, colour_in, div and corners; min/max of each axis pair becomes lo/hi; values above X_MAX/Y_MAX clamp to X_MAX/Y_MAX.
REQ-013 Mode 2 SHALL act as mode 0 with colour forced to 0 over the latched rectangle.
REQ-014 Modes 0-2: IDLE -> PLOT; busy=1 from the cycle after acceptance until DONE.
REQ-015 In PLOT, plot=1 for exactly one cycle with x,y,colour valid that same cycle; first pixel is (xlo,ylo), one cycle after the start edge.
REQ-016 Scan order SHALL be column-major: y increments first; at yhi, y wraps to ylo and x increments.
REQ-017 After each non-final pixel, WAIT SHALL hold plot=0 for exactly latched div cycles (div=0 skips WAIT: plot on consecutive cycles), then return to PLOT.
REQ-018 After pixel (xhi,yhi), SHALL enter DONE: done=1, busy=0 for one cycle, then IDLE.
REQ-019 Mode 1 colour SHALL start at 1, increment per plotted pixel, and wrap from 2^C_W-1 to 1, never emitting 0.
REQ-020 Mode 3: IDLE -> RSTPULSE (vga_resetn=0, busy=1, one cycle) -> DONE; no plot pulses.
REQ-021 Pixel count for a rectangle SHALL be (xhi-xlo+1)*(yhi-ylo+1); single-pixel rectangle gives one plot then DONE.
REQ-022 A start in the DONE cycle SHALL be ignored; a start in the following IDLE cycle is accepted.
REQ-023 x, y, colour SHALL hold last values when plot=0.
REQ-024 Counters SHALL never exceed X_MAX/Y_MAX; no wrap through 2^X_W.

Reset
REQ-025 reset SHALL take priority over all inputs including start in the same cycle.
REQ-026 After a reset edge: state IDLE, x=0, y=0, colour=0, plot=0, vga_resetn=1, busy=0, done=0.
REQ-027 Reset mid-PLOT/WAIT/RSTPULSE SHALL abort; no done pulse; no further plot.

Verification
REQ-028 Mode 0, (2,3)-(3,4), colour 5, div 0 -> plot on 4 consecutive cycles at (2,3),(2,4),(3,3),(3,4), colour 5, then done one cycle.
REQ-029 Mode 1, (0,0)-(0,9), div 2 -> 10 plots 3 cycles apart, colours 1..7,1,2,3.
REQ-030 Mode 0, x0=200,x1=158,y0=5,y1=5 -> x 158,159 at y=5 only, 2 plots.
REQ-031 Mode 3 -> vga_resetn low one cycle, then done, zero plots; mode 2 (0,0)-(0,0) colour_in 6 -> one plot colour 0.
REQ-032 Start re-pulsed during busy, then reset asserted with start high mid-WAIT -> second start ignored; next cycle all REQ-026 values, no done.
REQ-033 Start in DONE cycle ignored; start next cycle -> new operation, first plot one cycle later.
